// File: rtl/skew_pkg.sv
// Shared types and width helpers for the skewed tile buffer.
package skew_pkg;

    localparam int unsigned SKEW_DEF_BITS = 8;

    // Row index width for a DIM-row tile.
    function automatic int unsigned rowbits(input int unsigned dim);
        return (dim < 2) ? 1 : $clog2(dim);
    endfunction

    // Beat counter width covering 0..2*DIM-2.
    function automatic int unsigned tbits(input int unsigned dim);
        return $clog2(2 * dim - 1);
    endfunction

    typedef logic signed [SKEW_DEF_BITS-1:0] lane_t;

    typedef enum logic [0:0] {
        SKEW_ROW = 1'b0,
        SKEW_COL = 1'b1
    } skew_mode_e;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/skew_bank.sv
// One DIMxDIM tile store with a row write port and a diagonal skewed read.
module skew_bank
    import skew_pkg::*;
#(
    parameter int unsigned BITS    = 8,
    parameter int unsigned DIM     = 8,
    parameter int unsigned MODE    = 0,
    parameter int unsigned ROWBITS = rowbits(DIM),
    parameter int unsigned TBITS   = tbits(DIM)
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ROWBITS-1:0]            row,
    input  logic [DIM-1:0][BITS-1:0]      data,
    input  logic [TBITS-1:0]              t,
    output logic [DIM-1:0][BITS-1:0]      lanes
);

    localparam skew_mode_e ORIENT = (MODE == 1) ? SKEW_COL : SKEW_ROW;
    localparam logic signed [TBITS:0] DIM_S = (TBITS+1)'(DIM);

    logic [DIM-1:0][BITS-1:0] mem_q [DIM];
    logic signed [TBITS:0]    diff;

    // Row storage; contents survive reset and are only reachable once rewritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[row] <= data;
        end
    end

    // Diagonal read: lane i picks the element whose offset t-i lies inside the tile.
    always_comb begin
        lanes = '0;
        diff  = '0;
        for (int i = 0; i < DIM; i++) begin
            diff = $signed({1'b0, t}) - $signed((TBITS+1)'(i));
            if (!diff[TBITS] && (diff < DIM_S)) begin
                if (ORIENT == SKEW_COL) begin
                    lanes[i] = mem_q[diff[ROWBITS-1:0]][i];
                end else begin
                    lanes[i] = mem_q[i][diff[ROWBITS-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/skew_tile_buffer.sv
// Ping-pong tile buffer: loads tiles row by row, streams them back diagonally skewed.
module skew_tile_buffer
    import skew_pkg::*;
#(
    parameter int unsigned BITS = 8,
    parameter int unsigned DIM  = 8,
    parameter int unsigned MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DIM-1:0][BITS-1:0] wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIM-1:0][BITS-1:0] out_data,
    output logic                     out_first,
    output logic                     out_last,
    output logic [1:0]               full
);

    localparam int unsigned        ROWBITS  = rowbits(DIM);
    localparam int unsigned        TBITS    = tbits(DIM);
    localparam logic [ROWBITS-1:0] ROW_LAST = ROWBITS'(DIM - 1);
    localparam logic [TBITS-1:0]   T_LAST   = TBITS'(2 * DIM - 2);

    bank_state_e              state_q [2];
    bank_state_e              state_d [2];
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [ROWBITS-1:0]       wr_row_q, wr_row_d;
    logic [TBITS-1:0]         t_q, t_d;
    logic                     wr_fire, out_fire;
    logic                     wr_last, rd_last;
    logic [DIM-1:0][BITS-1:0] bank_lanes [2];

    // Handshake and status decode; every output depends on registered state only.
    assign full[0]   = (state_q[0] == BANK_FULL) || (state_q[0] == BANK_DRAINING);
    assign full[1]   = (state_q[1] == BANK_FULL) || (state_q[1] == BANK_DRAINING);
    assign wr_ready  = ~full[wr_bank_q];
    assign out_valid = full[rd_bank_q];
    assign wr_fire   = wr_valid & wr_ready;
    assign out_fire  = out_valid & out_ready;
    assign wr_last   = (wr_row_q == ROW_LAST);
    assign rd_last   = (t_q == T_LAST);
    assign out_first = out_valid & (t_q == '0);
    assign out_last  = out_valid & rd_last;
    assign out_data  = out_valid ? bank_lanes[rd_bank_q] : '0;

    // Control state register: bank FSMs, write/read bank pointers, row and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            t_q        <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            t_q        <= t_d;
        end
    end

    // Next-state: pointer advance on accepted beats, per-bank lifecycle transitions.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        t_d       = t_q;

        if (wr_fire) begin
            wr_row_d = wr_last ? '0 : wr_row_q + 1'b1;
            if (wr_last) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        if (out_fire) begin
            t_d = rd_last ? '0 : t_q + 1'b1;
            if (rd_last) begin
                rd_bank_d = ~rd_bank_q;
            end
        end

        for (int b = 0; b < 2; b++) begin
            case (state_q[b])
                BANK_EMPTY: begin
                    if (wr_fire && (wr_bank_q == 1'(b))) begin
                        state_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
                    end
                end
                BANK_FILLING: begin
                    if (wr_fire && (wr_bank_q == 1'(b)) && wr_last) begin
                        state_d[b] = BANK_FULL;
                    end
                end
                BANK_FULL: begin
                    if (out_fire && (rd_bank_q == 1'(b))) begin
                        state_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
                    end
                end
                BANK_DRAINING: begin
                    if (out_fire && (rd_bank_q == 1'(b)) && rd_last) begin
                        state_d[b] = BANK_EMPTY;
                    end
                end
                default: state_d[b] = BANK_EMPTY;
            endcase
        end
    end

    // Two tile stores; both see the beat counter, only the write bank sees the write strobe.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        skew_bank #(
            .BITS    (BITS),
            .DIM     (DIM),
            .MODE    (MODE),
            .ROWBITS (ROWBITS),
            .TBITS   (TBITS)
        ) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank_q == 1'(g))),
            .row   (wr_row_q),
            .data  (wr_data),
            .t     (t_q),
            .lanes (bank_lanes[g])
        );
    end

endmodule

// File: tb/tb_skew_tile_buffer.sv
// Directed bench: MODE0 and MODE1 instances share stimulus, outputs checked per beat.
module tb_skew_tile_buffer;
    import skew_pkg::*;

    localparam int unsigned DIM   = 4;
    localparam int unsigned BITS  = 8;
    localparam int          BEATS = 2 * DIM - 1;

    typedef logic [DIM-1:0][BITS-1:0]          row_t;
    typedef logic [DIM-1:0][DIM-1:0][BITS-1:0] tile_t;

    logic clk, rst, wr_valid, out_ready;
    row_t wr_data;
    logic wr_ready0, out_valid0, out_first0, out_last0;
    logic wr_ready1, out_valid1, out_first1, out_last1;
    row_t out_data0, out_data1;
    logic [1:0] full0, full1;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed lane 0 / lane 3 sequences for the 1..16 tile.
    int h_m0_l0 [BEATS] = '{1, 2, 3, 4, 0, 0, 0};
    int h_m0_l3 [BEATS] = '{0, 0, 0, 13, 14, 15, 16};
    int h_m1_l0 [BEATS] = '{1, 5, 9, 13, 0, 0, 0};
    int h_m1_l3 [BEATS] = '{0, 0, 0, 4, 8, 12, 16};

    skew_tile_buffer #(.BITS(BITS), .DIM(DIM), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_data(wr_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_first(out_first0), .out_last(out_last0), .full(full0)
    );

    skew_tile_buffer #(.BITS(BITS), .DIM(DIM), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_first(out_first1), .out_last(out_last1), .full(full1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic row_t mk_row(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    function automatic tile_t gen_tile(input int base);
        tile_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = 8'(base + r * DIM + c);
        return m;
    endfunction

    // Reference skew: lane i shows M[i][t-i] (row) or M[t-i][i] (col), zero outside.
    function automatic row_t exp_beat(input tile_t m, input bit col, input int t);
        row_t r = '0;
        for (int i = 0; i < DIM; i++) begin
            int k;
            k = t - i;
            if (k >= 0 && k < int'(DIM)) r[i] = col ? m[k][i] : m[i][k];
        end
        return r;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_row(input row_t r);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_data  = r;
        while (wr_ready0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wr_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write_tile(input tile_t m);
        for (int r = 0; r < DIM; r++) write_row(m[r]);
    endtask

    task automatic drain_tile(input tile_t m, input bit hand, input int stall_at, input int stall_len);
        out_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            if (b == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_hold_m0", out_data0, exp_beat(m, 1'b0, b));
                    check("stall_hold_m1", out_data1, exp_beat(m, 1'b1, b));
                    check("stall_valid", out_valid0, 1'b1);
                    check("stall_first", out_first0, 1'b0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check("beat_valid_m0", out_valid0, 1'b1);
            check("beat_valid_m1", out_valid1, 1'b1);
            check("beat_data_m0", out_data0, exp_beat(m, 1'b0, b));
            check("beat_data_m1", out_data1, exp_beat(m, 1'b1, b));
            check("beat_first", {out_first1, out_first0}, (b == 0) ? 2'b11 : 2'b00);
            check("beat_last", {out_last1, out_last0}, (b == BEATS - 1) ? 2'b11 : 2'b00);
            if (hand) begin
                check("hand_m0_lane0", out_data0[0], 64'(h_m0_l0[b]));
                check("hand_m0_lane3", out_data0[3], 64'(h_m0_l3[b]));
                check("hand_m1_lane0", out_data1[0], 64'(h_m1_l0[b]));
                check("hand_m1_lane3", out_data1[3], 64'(h_m1_l3[b]));
            end
            @(negedge clk);
        end
    endtask

    // Collects the back-to-back stream of three tiles and checks contiguity.
    task automatic read_stream(input tile_t t0, input tile_t t1, input tile_t t2);
        tile_t tl [3];
        int    n, w;
        bit    saw;
        tl[0] = t0; tl[1] = t1; tl[2] = t2;
        n = 0; w = 0; saw = 1'b0;
        while (out_valid0 !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (out_valid0 === 1'b1 && n < 30) begin
            check("pp_data_m0", out_data0, exp_beat(tl[n / BEATS], 1'b0, n % BEATS));
            check("pp_data_m1", out_data1, exp_beat(tl[n / BEATS], 1'b1, n % BEATS));
            if (full0 == 2'b11) begin
                saw = 1'b1;
                check("pp_wr_ready_both_full", wr_ready0, 1'b0);
            end
            n++;
            @(negedge clk);
        end
        check("pp_contiguous_beats", 64'(n), 64'd21);
        check("pp_saw_both_full", saw, 1'b1);
    endtask

    initial begin
        tile_t ta, tb, tc, ts;
        ta = gen_tile(1);
        tb = gen_tile(33);
        tc = gen_tile(101);
        ts[0] = mk_row(-128, 127, -1, 0);
        ts[1] = mk_row(127, -128, 1, -2);
        ts[2] = mk_row(0, -1, -128, 127);
        ts[3] = mk_row(-128, -128, 127, 127);

        // Reset state
        do_reset();
        check("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
        check("rst_full", {full1, full0}, 4'b0000);
        check("rst_wr_ready", {wr_ready1, wr_ready0}, 2'b11);
        check("rst_out_data", {out_data1, out_data0}, 64'd0);
        check("rst_first_last", {out_first0, out_last0}, 2'b00);

        // Single tile, both orientations, latency of one cycle after last row
        out_ready = 1'b1;
        for (int r = 0; r < DIM - 1; r++) write_row(ta[r]);
        check("lat_not_yet_valid", out_valid0, 1'b0);
        write_row(ta[DIM-1]);
        check("lat_valid_next_cycle", out_valid0, 1'b1);
        drain_tile(ta, 1'b1, -1, 0);
        check("after_drain_valid", out_valid0, 1'b0);
        check("after_drain_data", out_data0, 64'd0);
        check("after_drain_full", full0, 2'b00);

        // Ping-pong: three tiles back to back
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                write_tile(ta);
                write_tile(tb);
                write_tile(tc);
            end
            read_stream(ta, tb, tc);
        join

        // Back-pressure at beat 2 for 5 cycles
        do_reset();
        out_ready = 1'b1;
        write_tile(tb);
        drain_tile(tb, 1'b0, 2, 5);

        // Reset mid-drain at beat 3 with the other bank full
        do_reset();
        write_tile(ta);
        write_tile(tb);
        check("both_full", full0, 2'b11);
        check("both_full_wr_ready", wr_ready0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_drain_beat3", out_data0, exp_beat(ta, 1'b0, 3));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", {out_valid1, out_valid0}, 2'b00);
        check("mrst_full", {full1, full0}, 4'b0000);
        check("mrst_out_data", {out_data1, out_data0}, 64'd0);
        check("mrst_wr_ready", {wr_ready1, wr_ready0}, 2'b11);
        rst = 1'b0;
        write_tile(tc);
        drain_tile(tc, 1'b0, -1, 0);

        // Signed extremes pass through bit-exact with zero padding
        do_reset();
        out_ready = 1'b1;
        write_tile(ts);
        check("signed_beat0_m0", out_data0, 32'h0000_0080);
        check("signed_beat0_m1", out_data1, 32'h0000_0080);
        drain_tile(ts, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
